// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the KxK convolution engine.
// Contents: engine state enum, default width constants, and the
// round_shift / sat_signed helpers. The helpers work on a 64-bit signed
// carrier, so every width they are given must stay below 64.
package conv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StRound,
    StOut
  } conv_state_e;

  localparam int unsigned DefK       = 7;
  localparam int unsigned DefDataW   = 21;
  localparam int unsigned DefWeightW = 18;
  localparam int unsigned DefFrac    = 17;
  localparam int unsigned DefAccW    = 48;
  localparam int unsigned DefCoordW  = 5;

  // Add half an LSB, then shift right arithmetically. Ties therefore round
  // toward +infinity.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                     input int unsigned frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (x + half) >>> frac;
  endfunction

  // Clamp x to the range of a signed number that is width bits wide.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/conv_row_mac.sv
// Combinational K-way signed dot product of one weight row and one window row.
// Ports:
//   w_vec  : K weights, with element c at [c*WEIGHT_W +: WEIGHT_W]
//   x_vec  : K pixels, with element c at [c*DATA_W +: DATA_W]
//   dot    : full-precision sum of the K products
module conv_row_mac #(
  parameter int unsigned K        = 7,
  parameter int unsigned DATA_W   = 21,
  parameter int unsigned WEIGHT_W = 18,
  parameter int unsigned OUT_W    = DATA_W + WEIGHT_W + $clog2(K)
) (
  input  logic [K*WEIGHT_W-1:0]   w_vec,
  input  logic [K*DATA_W-1:0]     x_vec,
  output logic signed [OUT_W-1:0] dot
);

  localparam int unsigned ProdW = DATA_W + WEIGHT_W;

  logic signed [ProdW-1:0] prod;

  always_comb begin
    dot  = '0;
    prod = '0;
    for (int c = 0; c < int'(K); c++) begin
      prod = $signed(w_vec[c*WEIGHT_W +: WEIGHT_W]) * $signed(x_vec[c*DATA_W +: DATA_W]);
      dot  = dot + $signed({{(OUT_W - ProdW){prod[ProdW-1]}}, prod});
    end
  end

endmodule

// File: rtl/conv_kxk_engine.sv
// KxK signed fixed-point convolution engine with a sliding column window.
// The engine accepts one K-pixel column per handshake. Once K columns have
// arrived in the current image row, it runs one multiply-accumulate per kernel
// row (K cycles). It then rounds, shifts, saturates and optionally applies
// ReLU, and holds the pixel on the output until downstream accepts it.
// Ports:
//   clk_in, rst_in                : clock and synchronous active-high reset
//   in_valid/in_ready, data_in    : column input; row r at [r*DATA_W +: DATA_W]
//   hcount_in, vcount_in          : coordinates of the column; hcount 0 starts a row
//   w_load, w_row, w_data         : write one kernel row (column c at [c*WEIGHT_W +: ...])
//   bias_load, bias_in            : write the bias, given in product Q format
//   relu_en                       : clamp negative results to zero
//   out_valid/out_ready, data_out : result pixel handshake
//   sat_out                       : the result was clamped
//   hcount_out, vcount_out        : coordinates of the column that completed the window
module conv_kxk_engine
  import conv_pkg::*;
#(
  parameter int unsigned K        = DefK,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned WEIGHT_W = DefWeightW,
  parameter int unsigned FRAC     = DefFrac,
  parameter int unsigned ACC_W    = DefAccW,
  parameter int unsigned COORD_W  = DefCoordW
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K*DATA_W-1:0]      data_in,
  input  logic [COORD_W-1:0]       hcount_in,
  input  logic [COORD_W-1:0]       vcount_in,
  input  logic                     w_load,
  input  logic [$clog2(K)-1:0]     w_row,
  input  logic [K*WEIGHT_W-1:0]    w_data,
  input  logic                     bias_load,
  input  logic signed [ACC_W-1:0]  bias_in,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     sat_out,
  output logic [COORD_W-1:0]       hcount_out,
  output logic [COORD_W-1:0]       vcount_out
);

  localparam int unsigned RowW  = $clog2(K);
  localparam int unsigned FillW = $clog2(K + 1);
  localparam int unsigned DotW  = DATA_W + WEIGHT_W + $clog2(K);

  conv_state_e              state_q;
  logic signed [DATA_W-1:0]   win_q [K][K];  // [column][row]; column 0 is the oldest
  logic signed [WEIGHT_W-1:0] w_q   [K][K];  // [row][column]
  logic signed [ACC_W-1:0]    bias_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [FillW-1:0]           fill_q;
  logic [FillW-1:0]           fill_new;
  logic [RowW-1:0]            r_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic signed [DATA_W-1:0]   data_out_q;
  logic                       sat_q;
  logic [COORD_W-1:0]         hcount_q;
  logic [COORD_W-1:0]         vcount_q;
  logic                       accept;

  logic [K*WEIGHT_W-1:0]      w_vec;
  logic [K*DATA_W-1:0]        x_vec;
  logic signed [DotW-1:0]     dot;

  logic signed [63:0]         acc_ext;
  logic signed [63:0]         rounded;
  logic signed [63:0]         clamped;
  logic signed [DATA_W-1:0]   res;
  logic                       res_sat;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign sat_out    = sat_q;
  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;

  assign accept = in_valid && in_ready_q && (state_q == StIdle);

  // A column at hcount 0 starts a new image row. Older columns stay in the
  // window but no longer count toward a full window.
  always_comb begin
    if (hcount_in == '0) begin
      fill_new = FillW'(1);
    end else if (fill_q == FillW'(K)) begin
      fill_new = fill_q;
    end else begin
      fill_new = fill_q + FillW'(1);
    end
  end

  // Select the operands for the current kernel row.
  always_comb begin
    w_vec = '0;
    x_vec = '0;
    for (int c = 0; c < int'(K); c++) begin
      w_vec[c*WEIGHT_W +: WEIGHT_W] = w_q[r_q][c];
      x_vec[c*DATA_W +: DATA_W]     = win_q[c][r_q];
    end
  end

  conv_row_mac #(
    .K        (K),
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .OUT_W    (DotW)
  ) u_row_mac (
    .w_vec (w_vec),
    .x_vec (x_vec),
    .dot   (dot)
  );

  always_comb begin
    acc_ext = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    rounded = round_shift(acc_ext, FRAC);
    clamped = sat_signed(rounded, DATA_W);
    res_sat = (clamped != rounded);
    res     = clamped[DATA_W-1:0];
    // ReLU is applied after saturation, so it never sets the sat flag.
    if (relu_en && clamped[63]) res = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      fill_q      <= '0;
      r_q         <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_q       <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      for (int c = 0; c < int'(K); c++) begin
        for (int r = 0; r < int'(K); r++) begin
          win_q[c][r] <= '0;
          w_q[r][c]   <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (w_load && (int'(w_row) < int'(K))) begin
            for (int c = 0; c < int'(K); c++) begin
              w_q[w_row][c] <= $signed(w_data[c*WEIGHT_W +: WEIGHT_W]);
            end
          end
          if (bias_load) bias_q <= bias_in;
          if (accept) begin
            for (int c = 0; c < int'(K) - 1; c++) begin
              for (int r = 0; r < int'(K); r++) win_q[c][r] <= win_q[c+1][r];
            end
            for (int r = 0; r < int'(K); r++) begin
              win_q[K-1][r] <= $signed(data_in[r*DATA_W +: DATA_W]);
            end
            fill_q <= fill_new;
            if (fill_new == FillW'(K)) begin
              state_q    <= StMac;
              in_ready_q <= 1'b0;
              r_q        <= '0;
              // A bias written in this same cycle applies to this result.
              acc_q      <= bias_load ? bias_in : bias_q;
              hcount_q   <= hcount_in;
              vcount_q   <= vcount_in;
            end
          end
        end
        StMac: begin
          acc_q <= acc_q + $signed({{(ACC_W - DotW){dot[DotW-1]}}, dot});
          r_q   <= r_q + RowW'(1);
          if (r_q == RowW'(K - 1)) state_q <= StRound;
        end
        StRound: begin
          data_out_q  <= res;
          sat_q       <= res_sat;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_kxk_engine.sv
// Self-checking bench for conv_kxk_engine at K=3, DATA_W=21, WEIGHT_W=18, FRAC=4.
// The reference model keeps the window and weights as plain arrays. It computes
// each result with longint arithmetic and floor division.
module tb_conv_kxk_engine;

  localparam int K        = 3;
  localparam int DATA_W   = 21;
  localparam int WEIGHT_W = 18;
  localparam int FRAC     = 4;
  localparam int ACC_W    = 48;
  localparam int COORD_W  = 5;
  localparam int RowW     = $clog2(K);
  localparam int DW       = K * DATA_W;
  localparam int WW       = K * WEIGHT_W;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     in_valid;
  logic                     in_ready;
  logic [DW-1:0]            data_in;
  logic [COORD_W-1:0]       hcount_in;
  logic [COORD_W-1:0]       vcount_in;
  logic                     w_load;
  logic [RowW-1:0]          w_row;
  logic [WW-1:0]            w_data;
  logic                     bias_load;
  logic signed [ACC_W-1:0]  bias_in;
  logic                     relu_en;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] data_out;
  logic                     sat_out;
  logic [COORD_W-1:0]       hcount_out;
  logic [COORD_W-1:0]       vcount_out;

  always #5 clk_in = ~clk_in;

  conv_kxk_engine #(
    .K        (K),
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .FRAC     (FRAC),
    .ACC_W    (ACC_W),
    .COORD_W  (COORD_W)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .w_load     (w_load),
    .w_row      (w_row),
    .w_data     (w_data),
    .bias_load  (bias_load),
    .bias_in    (bias_in),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .sat_out    (sat_out),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  longint             m_win [K][K];  // [column][row]
  longint             m_w   [K][K];  // [row][column]
  longint             m_bias;
  int                 m_fill;
  bit                 m_expect;
  bit                 m_relu;
  logic [COORD_W-1:0] m_h;
  logic [COORD_W-1:0] m_v;
  longint             nxt_col [K];

  typedef struct {
    bit     all;       // 1: every weight and pixel set; 0: only w[0][0] and win[0][0]
    longint pix;
    longint w;
    bit     relu;
    longint exp_data;
    bit     exp_sat;
  } vec_t;
  vec_t vecs[$];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic longint rand_signed(input int w);
    longint v;
    v = longint'({$urandom, $urandom}) & ((longint'(1) << w) - 1);
    if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic longint rand_range(input int lim);
    return longint'($urandom_range(0, 2 * lim)) - longint'(lim);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < K; c++)
      for (int r = 0; r < K; r++) begin
        m_win[c][r] = 0;
        m_w[r][c]   = 0;
      end
    m_bias   = 0;
    m_fill   = 0;
    m_expect = 0;
  endtask

  task automatic model_accept(input logic [COORD_W-1:0] h, input logic [COORD_W-1:0] v);
    for (int c = 0; c < K - 1; c++)
      for (int r = 0; r < K; r++) m_win[c][r] = m_win[c+1][r];
    for (int r = 0; r < K; r++) m_win[K-1][r] = nxt_col[r];
    if (h == 0) m_fill = 1;
    else if (m_fill < K) m_fill++;
    m_expect = (m_fill == K);
    if (m_expect) begin
      m_h = h;
      m_v = v;
    end
  endtask

  task automatic model_eval(output longint v, output bit sat);
    longint acc, t, d, hi, lo;
    acc = m_bias;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) acc += m_w[r][c] * m_win[c][r];
    d = longint'(1) << FRAC;
    t = acc + d / 2;
    v = t / d;
    if (t < 0 && (t % d) != 0) v = v - 1;
    hi  = (longint'(1) << (DATA_W - 1)) - 1;
    lo  = -(hi + 1);
    sat = 0;
    if (v > hi) begin v = hi; sat = 1; end
    if (v < lo) begin v = lo; sat = 1; end
    if (m_relu && v < 0) v = 0;
  endtask

  task automatic push_weights();
    for (int r = 0; r < K; r++) begin
      w_load = 1'b1;
      w_row  = RowW'(r);
      for (int c = 0; c < K; c++) w_data[c*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(m_w[r][c]);
      step();
    end
    w_load = 1'b0;
  endtask

  task automatic push_bias();
    bias_load = 1'b1;
    bias_in   = ACC_W'(m_bias);
    step();
    bias_load = 1'b0;
  endtask

  // Drive nxt_col with the given coordinates and wait for the accept. Any
  // w_load or bias_load the caller set up goes out in the same cycle.
  task automatic apply_col(input int h, input int v, input bit relu);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) fail_now("in_ready_wait");
    in_valid  = 1'b1;
    hcount_in = COORD_W'(h);
    vcount_in = COORD_W'(v);
    relu_en   = relu;
    m_relu    = relu;
    for (int r = 0; r < K; r++) data_in[r*DATA_W +: DATA_W] = DATA_W'(nxt_col[r]);
    step();
    in_valid  = 1'b0;
    w_load    = 1'b0;
    bias_load = 1'b0;
    model_accept(COORD_W'(h), COORD_W'(v));
  endtask

  // Collect the result of the last accept (if one is due), stall downstream
  // for a number of cycles, then hand it off.
  task automatic finish_window(input int stall, input bit garbage,
                               output longint got_d, output bit got_s);
    longint ev;
    bit     es;
    int     lat;
    got_d = 0;
    got_s = 0;
    if (!m_expect) begin
      check("no_out_valid", out_valid, 0);
      check("no_out_ready", in_ready, 1);
      return;
    end
    model_eval(ev, es);
    out_ready = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 4 * K + 10) begin
      check("busy_in_ready", in_ready, 0);
      if (garbage) begin
        // Writes while busy must be ignored.
        w_load    = 1'($urandom);
        w_row     = RowW'($urandom_range(0, K - 1));
        w_data    = WW'({$urandom, $urandom});
        bias_load = 1'($urandom);
        bias_in   = ACC_W'({$urandom, $urandom});
      end
      step();
      lat++;
    end
    w_load    = 1'b0;
    bias_load = 1'b0;
    check("latency", lat, K + 1);
    check("data_out", data_out, ev);
    check("sat_out", sat_out, es);
    check("hcount_out", hcount_out, m_h);
    check("vcount_out", vcount_out, m_v);
    got_d = data_out;
    got_s = sat_out;
    for (int i = 0; i < stall; i++) begin
      in_valid  = 1'b1;
      data_in   = DW'({$urandom, $urandom});
      hcount_in = '0;
      step();
      check("stall_valid", out_valid, 1);
      check("stall_data", data_out, ev);
      check("stall_sat", sat_out, es);
      check("stall_hcount", hcount_out, m_h);
      check("stall_vcount", vcount_out, m_v);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint gd;
    bit     gs;
    int     h_prev;
    in_valid  = 1'b0;
    data_in   = '0;
    hcount_in = '0;
    vcount_in = '0;
    w_load    = 1'b0;
    w_row     = '0;
    w_data    = '0;
    bias_load = 1'b0;
    bias_in   = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    m_relu    = 0;
    m_h       = '0;
    m_v       = '0;
    model_reset();

    // Reset values.
    rst_in = 1'b1;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sat_out", sat_out, 0);
    check("rst_hcount_out", hcount_out, 0);
    check("rst_vcount_out", vcount_out, 0);
    rst_in = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Table of single-window cases: unit gain, rounding, saturation, ReLU.
    vecs.push_back('{1, 2, 16, 0, 18, 0});
    vecs.push_back('{0, 8, 1, 0, 1, 0});
    vecs.push_back('{0, -8, 1, 0, 0, 0});
    vecs.push_back('{0, -9, 1, 0, -1, 0});
    vecs.push_back('{0, -9, 1, 1, 0, 0});
    vecs.push_back('{0, 24, 1, 0, 2, 0});
    vecs.push_back('{0, 23, 1, 0, 1, 0});
    vecs.push_back('{0, -24, 1, 0, -1, 0});
    vecs.push_back('{1, 1048575, 131071, 0, 1048575, 1});
    vecs.push_back('{1, -1048575, 131071, 1, 0, 1});
    vecs.push_back('{1, -1048575, 131071, 0, -1048576, 1});
    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          m_w[r][c] = (vecs[i].all || (r == 0 && c == 0)) ? vecs[i].w : 0;
      m_bias = 0;
      push_weights();
      push_bias();
      for (int col = 0; col < K; col++) begin
        for (int r = 0; r < K; r++)
          nxt_col[r] = (vecs[i].all || (col == 0 && r == 0)) ? vecs[i].pix : 0;
        apply_col(col, i, vecs[i].relu);
      end
      finish_window(0, 0, gd, gs);
      check("vec_data", gd, vecs[i].exp_data);
      check("vec_sat", gs, vecs[i].exp_sat);
    end

    // Row restart: hcount 0 in the middle discards the partial window.
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) m_w[r][c] = rand_range(200);
    m_bias = rand_range(5000);
    push_weights();
    push_bias();
    for (int j = 0; j < 5; j++) begin
      for (int r = 0; r < K; r++) nxt_col[r] = rand_range(3000);
      apply_col((j < 2) ? j : j - 2, 7, 0);
      finish_window(0, 0, gd, gs);
    end

    // Long downstream stall with columns offered. Then one more column must see
    // the undisturbed window.
    for (int r = 0; r < K; r++) nxt_col[r] = rand_range(3000);
    apply_col(3, 8, 0);
    finish_window(10, 0, gd, gs);
    for (int r = 0; r < K; r++) nxt_col[r] = rand_range(3000);
    apply_col(4, 8, 0);
    finish_window(0, 1, gd, gs);

    // Reset in the middle of MAC aborts the computation.
    for (int r = 0; r < K; r++) nxt_col[r] = rand_range(3000);
    apply_col(5, 9, 0);
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    model_reset();
    for (int i = 0; i < K + 4; i++) begin
      step();
      check("abort_out_valid", out_valid, 0);
    end
    check("abort_in_ready", in_ready, 1);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) m_w[r][c] = rand_range(200);
    m_bias = rand_range(5000);
    push_weights();
    push_bias();
    for (int j = 0; j < K; j++) begin
      for (int r = 0; r < K; r++) nxt_col[r] = rand_range(3000);
      apply_col(6 + j, 10, 0);
      finish_window(0, 0, gd, gs);
    end

    // Randomised traffic with row restarts, same-cycle writes and stalls.
    h_prev = 8;
    for (int it = 0; it < 80; it++) begin
      bit big;
      int h;
      big = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            m_w[r][c] = big ? rand_signed(WEIGHT_W) : rand_range(300);
        m_bias = big ? rand_signed(44) : rand_signed(30);
        push_weights();
        push_bias();
      end
      for (int r = 0; r < K; r++) nxt_col[r] = big ? rand_signed(DATA_W) : rand_range(3000);
      h = ($urandom_range(0, 4) == 0 || h_prev >= 31) ? 0 : h_prev + 1;
      h_prev = h;
      if ($urandom_range(0, 3) == 0) begin
        int rr;
        rr = $urandom_range(0, K - 1);
        for (int c = 0; c < K; c++) begin
          m_w[rr][c] = big ? rand_signed(WEIGHT_W) : rand_range(300);
          w_data[c*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(m_w[rr][c]);
        end
        w_load    = 1'b1;
        w_row     = RowW'(rr);
        m_bias    = rand_signed(30);
        bias_load = 1'b1;
        bias_in   = ACC_W'(m_bias);
      end
      apply_col(h, $urandom_range(0, 31), 1'($urandom));
      finish_window($urandom_range(0, 3), 1'($urandom), gd, gs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
